// File: rtl/counter_stim_driver.sv
// Command-driven stimulus initiator for a 3-bit loadable counter: LOAD and INC bursts over ld/inc/data_in.
// Define STIM_READBACK_EN to build in expected-value tracking and the readback mismatch check.
module counter_stim_driver #(
    parameter int WIDTH = 3,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             ctr_ld,
    output logic             ctr_inc,
    output logic [WIDTH-1:0] ctr_data_in,
    input  logic [WIDTH-1:0] ctr_data_out,
    output logic             done,
    input  logic             clr_err,
    output logic             err_sat,
    output logic             err_mismatch
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // LD    | one-cycle load strobe
    // INC   | one-cycle increment strobe
    // CHK   | readback check and burst continue/finish decision
    typedef enum logic [1:0] {IDLE, LD, INC, CHK} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] rem;
    logic             accept;
    logic             sat_hit;

    assign cmd_ready = (state == IDLE) && rst;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nxt = state;
        ctr_ld    = 1'b0;
        ctr_inc   = 1'b0;
        done      = 1'b0;
        sat_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = cmd_op ? CHK : LD;
            end
            LD: begin
                ctr_ld    = 1'b1;
                state_nxt = CHK;
            end
            INC: begin
                ctr_inc   = 1'b1;
                state_nxt = CHK;
            end
            CHK: begin
                if (rem == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (ctr_data_out == {WIDTH{1'b1}}) begin
                    // Stop short rather than wrap the counter.
                    sat_hit   = 1'b1;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = INC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rem         <= '0;
            ctr_data_in <= '0;
            err_sat     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem <= cmd_len;
                if (!cmd_op) ctr_data_in <= cmd_data;
            end else if (state == INC) begin
                rem <= rem - LEN_W'(1);
            end else if (sat_hit) begin
                rem <= '0;
            end
            if (sat_hit)      err_sat <= 1'b1;
            else if (clr_err) err_sat <= 1'b0;
        end
    end

`ifdef STIM_READBACK_EN
    logic [WIDTH-1:0] exp_val;
    logic             first;
    logic             mism;

    assign mism = (state == CHK) && !first && (ctr_data_out != exp_val);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_val      <= '0;
            first        <= 1'b0;
            err_mismatch <= 1'b0;
        end else begin
            if (accept) first <= cmd_op;
            else if (state == CHK) first <= 1'b0;

            // A burst starts from whatever the counter currently holds.
            if (state == LD)                 exp_val <= ctr_data_in;
            else if (state == CHK && first)  exp_val <= ctr_data_out;
            else if (state == INC)           exp_val <= exp_val + WIDTH'(1);

            if (mism)         err_mismatch <= 1'b1;
            else if (clr_err) err_mismatch <= 1'b0;
        end
    end
`else
    assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_counter_stim_driver.sv
// Directed bench for counter_stim_driver with a behavioural 3-bit counter (optionally stuck) on the far side.
module tb_counter_stim_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [2:0] cmd_data = 3'd0;
    logic [3:0] cmd_len = 4'd0;
    logic       ctr_ld, ctr_inc, done, err_sat, err_mismatch;
    logic [2:0] ctr_data_in;
    logic [2:0] cnt = 3'd0;
    logic       clr_err = 1'b0;
    logic       stuck = 1'b0;

    int checks = 0;
    int errors = 0;

    counter_stim_driver #(.WIDTH(3), .LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_len(cmd_len),
        .ctr_ld(ctr_ld), .ctr_inc(ctr_inc), .ctr_data_in(ctr_data_in),
        .ctr_data_out(cnt), .done(done), .clr_err(clr_err),
        .err_sat(err_sat), .err_mismatch(err_mismatch)
    );

    always #5 clk = ~clk;

    // Counter under drive; "stuck" freezes it to provoke readback errors.
    always @(posedge clk) begin
        if (!stuck) begin
            if (ctr_ld)       cnt <= ctr_data_in;
            else if (ctr_inc) cnt <= cnt + 3'd1;
        end
    end

    // Returns at the falling edge of the cycle after the accept edge (k=1).
    task automatic send_cmd(input logic op, input logic [2:0] d, input logic [3:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (ctr_ld !== 1'b0 || ctr_inc !== 1'b0 || done !== 1'b0 || ctr_data_in !== 3'd0 ||
            err_sat !== 1'b0 || err_mismatch !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ld=%b inc=%b done=%b din=%0d sat=%b mis=%b rdy=%b, expected all 0",
                     ctr_ld, ctr_inc, done, ctr_data_in, err_sat, err_mismatch, cmd_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_load;
        send_cmd(1'b0, 3'd5, 4'd0);
        checks++;
        if (ctr_ld !== 1'b1 || ctr_data_in !== 3'd5 || ctr_inc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_t1: ld=%b inc=%b din=%0d done=%b, expected ld=1 inc=0 din=5 done=0",
                     ctr_ld, ctr_inc, ctr_data_in, done);
        end
        @(negedge clk);
        checks++;
        if (ctr_ld !== 1'b0 || done !== 1'b1 || cnt !== 3'd5) begin
            errors++;
            $display("FAIL load_t2: ld=%b done=%b cnt=%0d, expected ld=0 done=1 cnt=5", ctr_ld, done, cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err_sat !== 1'b0 || err_mismatch !== 1'b0 || cmd_ready !== 1'b1 ||
            ctr_data_in !== 3'd5) begin
            errors++;
            $display("FAIL load_t3: done=%b sat=%b mis=%b rdy=%b din=%0d, expected 0 0 0 1 5",
                     done, err_sat, err_mismatch, cmd_ready, ctr_data_in);
        end
    endtask

    task automatic test_burst;
        send_cmd(1'b0, 3'd2, 4'd0);
        @(negedge clk);
        send_cmd(1'b1, 3'd0, 4'd3);
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (ctr_inc !== ((k % 2 == 0) && k <= 6) || done !== (k == 7) || ctr_ld !== 1'b0) begin
                errors++;
                $display("FAIL burst_k%0d: inc=%b done=%b ld=%b, expected inc=%b done=%b ld=0",
                         k, ctr_inc, done, ctr_ld, (k % 2 == 0) && k <= 6, k == 7);
            end
        end
        checks++;
        if (cnt !== 3'd5) begin
            errors++;
            $display("FAIL burst_count: got %0d expected 5", cnt);
        end
        @(negedge clk);
        checks++;
        if (err_sat !== 1'b0 || err_mismatch !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL burst_errs: sat=%b mis=%b rdy=%b, expected 0 0 1", err_sat, err_mismatch, cmd_ready);
        end
    endtask

    task automatic test_saturation;
        send_cmd(1'b0, 3'd6, 4'd0);
        @(negedge clk);
        send_cmd(1'b1, 3'd0, 4'd4);
        checks++;
        if (ctr_inc !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL sat_k1: inc=%b done=%b expected 0 0", ctr_inc, done);
        end
        @(negedge clk);
        checks++;
        if (ctr_inc !== 1'b1) begin
            errors++;
            $display("FAIL sat_k2_inc: got %b expected 1", ctr_inc);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || ctr_inc !== 1'b0 || cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_k3: done=%b inc=%b cnt=%0d, expected done=1 inc=0 cnt=7", done, ctr_inc, cnt);
        end
        @(negedge clk);
        checks++;
        if (err_sat !== 1'b1 || ctr_inc !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || err_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL sat_k4: sat=%b inc=%b done=%b rdy=%b mis=%b, expected 1 0 0 1 0",
                     err_sat, ctr_inc, done, cmd_ready, err_mismatch);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (err_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %b expected 0", err_sat);
        end
    endtask

    task automatic test_clr_priority;
        clr_err = 1'b1;
        send_cmd(1'b1, 3'd0, 4'd1);
        checks++;
        if (done !== 1'b1 || ctr_inc !== 1'b0) begin
            errors++;
            $display("FAIL clrpri_k1: done=%b inc=%b expected 1 0", done, ctr_inc);
        end
        @(negedge clk);
        checks++;
        if (err_sat !== 1'b1) begin
            errors++;
            $display("FAIL clrpri_set_wins: got %b expected 1", err_sat);
        end
        @(negedge clk);
        clr_err = 1'b0;
        checks++;
        if (err_sat !== 1'b0) begin
            errors++;
            $display("FAIL clrpri_cleared: got %b expected 0", err_sat);
        end
    endtask

    task automatic test_zero_len;
        send_cmd(1'b1, 3'd0, 4'd0);
        checks++;
        if (done !== 1'b1 || ctr_ld !== 1'b0 || ctr_inc !== 1'b0) begin
            errors++;
            $display("FAIL zero_k1: done=%b ld=%b inc=%b expected 1 0 0", done, ctr_ld, ctr_inc);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || ctr_ld !== 1'b0 || ctr_inc !== 1'b0) begin
            errors++;
            $display("FAIL zero_k2: rdy=%b done=%b ld=%b inc=%b expected 1 0 0 0", cmd_ready, done, ctr_ld, ctr_inc);
        end
    endtask

    task automatic test_mismatch;
        logic exp_mis;
`ifdef STIM_READBACK_EN
        exp_mis = 1'b1;
`else
        exp_mis = 1'b0;
`endif
        send_cmd(1'b0, 3'd3, 4'd0);
        @(negedge clk);
        stuck = 1'b1;
        send_cmd(1'b1, 3'd0, 4'd2);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (done !== (k == 5) || ctr_inc !== (k == 2 || k == 4)) begin
                errors++;
                $display("FAIL mis_k%0d: done=%b inc=%b expected done=%b inc=%b",
                         k, done, ctr_inc, k == 5, k == 2 || k == 4);
            end
        end
        @(negedge clk);
        checks++;
        if (err_mismatch !== exp_mis || err_sat !== 1'b0) begin
            errors++;
            $display("FAIL mis_flag: mis=%b sat=%b expected mis=%b sat=0", err_mismatch, err_sat, exp_mis);
        end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        stuck = 1'b0;
        checks++;
        if (err_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mis_clear: got %b expected 0", err_mismatch);
        end
    endtask

    task automatic test_reset_mid;
        send_cmd(1'b0, 3'd1, 4'd0);
        @(negedge clk);
        send_cmd(1'b1, 3'd0, 4'd5);
        repeat (3) @(negedge clk);
        checks++;
        if (ctr_inc !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_second_inc: got %b expected 1", ctr_inc);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctr_ld !== 1'b0 || ctr_inc !== 1'b0 || done !== 1'b0 || ctr_data_in !== 3'd0 ||
            err_sat !== 1'b0 || err_mismatch !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: ld=%b inc=%b done=%b din=%0d sat=%b mis=%b rdy=%b, expected all 0",
                     ctr_ld, ctr_inc, done, ctr_data_in, err_sat, err_mismatch, cmd_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || ctr_inc !== 1'b0 || ctr_ld !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_held%0d: done=%b inc=%b ld=%b expected 0 0 0", k, done, ctr_inc, ctr_ld);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready: got %b expected 1", cmd_ready);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || ctr_inc !== 1'b0 || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_idle%0d: done=%b inc=%b rdy=%b expected 0 0 1", k, done, ctr_inc, cmd_ready);
            end
        end
        send_cmd(1'b0, 3'd4, 4'd0);
        checks++;
        if (ctr_ld !== 1'b1 || ctr_data_in !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_recover: ld=%b din=%0d expected 1 4", ctr_ld, ctr_data_in);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || cnt !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_recover_done: done=%b cnt=%0d expected 1 4", done, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_burst();
        test_saturation();
        test_clr_priority();
        test_zero_len();
        test_mismatch();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
